// File: rtl/bg_pkg.sv
// Shared constants for the background scroll address path:
// scroll mode encodings and default source/screen geometry.
package bg_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_H      = 2'b01,
        MODE_V      = 2'b10,
        MODE_DIAG   = 2'b11
    } scroll_mode_e;

    localparam int BG_SRC_W    = 320;
    localparam int BG_SRC_H    = 240;
    localparam int BG_H_ACTIVE = 640;
    localparam int BG_V_ACTIVE = 480;

endpackage

// File: rtl/bg_offset_wrap.sv
// Modular add/subtract of a 0..15 step against LIMIT; cur must already be < LIMIT.
module bg_offset_wrap #(
    parameter int W     = 9,
    parameter int LIMIT = 320
) (
    input  logic [W-1:0] cur,
    input  logic [3:0]   step,
    input  logic         neg,
    output logic [W-1:0] nxt
);

    logic [W:0] sum;

    // step < LIMIT, so one correction in either direction is enough
    always_comb begin
        sum = {1'b0, cur} + (W+1)'(step);
        if (neg) begin
            if (cur < W'(step))
                nxt = W'({1'b0, cur} + (W+1)'(LIMIT) - (W+1)'(step));
            else
                nxt = cur - W'(step);
        end else begin
            if (sum >= (W+1)'(LIMIT))
                nxt = W'(sum - (W+1)'(LIMIT));
            else
                nxt = W'(sum);
        end
    end

endmodule

// File: rtl/bg_scroll_addr_gen.sv
// Maps VGA h_cnt/v_cnt to a scaled, wrap-scrolled background ROM address.
// Offsets latch at frame start; pixel_valid is aligned with ROM read data.
module bg_scroll_addr_gen
    import bg_pkg::*;
#(
    parameter int SRC_W       = BG_SRC_W,
    parameter int SRC_H       = BG_SRC_H,
    parameter int SCALE_SHIFT = 1,
    parameter int H_ACTIVE    = BG_H_ACTIVE,
    parameter int V_ACTIVE    = BG_V_ACTIVE,
    parameter int ADDR_W      = 17,
    parameter int MEM_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    input  logic [1:0]        scroll_mode,
    input  logic              step_tick,
    input  logic [3:0]        step,
    input  logic              step_neg,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              pixel_valid,
    output logic [8:0]        x_off,
    output logic [7:0]        y_off
);

    logic [8:0]  px, px_nxt;
    logic [7:0]  py, py_nxt;
    logic        x_move, y_move, frame_start;
    logic [10:0] sum_x, sum_y, sx1, sy1;
    logic        act1, act2;

    bg_offset_wrap #(.W(9), .LIMIT(SRC_W)) u_wrap_x (
        .cur(px), .step(step), .neg(step_neg), .nxt(px_nxt)
    );

    bg_offset_wrap #(.W(8), .LIMIT(SRC_H)) u_wrap_y (
        .cur(py), .step(step), .neg(step_neg), .nxt(py_nxt)
    );

    assign x_move      = (scroll_mode == MODE_H) || (scroll_mode == MODE_DIAG);
    assign y_move      = (scroll_mode == MODE_V) || (scroll_mode == MODE_DIAG);
    assign frame_start = (v_cnt == 10'(V_ACTIVE)) && (h_cnt == 10'd0);

    // Active offsets sample the pre-tick pending value when both coincide
    always_ff @(posedge clk) begin
        if (!rst) begin
            px    <= '0;
            py    <= '0;
            x_off <= '0;
            y_off <= '0;
        end else begin
            if (step_tick && x_move) px <= px_nxt;
            if (step_tick && y_move) py <= py_nxt;
            if (frame_start) begin
                x_off <= px;
                y_off <= py;
            end
        end
    end

    assign sum_x = 11'(h_cnt >> SCALE_SHIFT) + 11'(x_off);
    assign sum_y = 11'(v_cnt >> SCALE_SHIFT) + 11'(y_off);

    always_ff @(posedge clk) begin
        if (!rst) begin
            sx1        <= '0;
            sy1        <= '0;
            act1       <= 1'b0;
            pixel_addr <= '0;
            act2       <= 1'b0;
        end else begin
            sx1        <= (sum_x >= 11'(SRC_W)) ? sum_x - 11'(SRC_W) : sum_x;
            sy1        <= (sum_y >= 11'(SRC_H)) ? sum_y - 11'(SRC_H) : sum_y;
            act1       <= (h_cnt < 10'(H_ACTIVE)) && (v_cnt < 10'(V_ACTIVE));
            pixel_addr <= act1 ? ADDR_W'(ADDR_W'(sy1) * ADDR_W'(SRC_W) + ADDR_W'(sx1)) : '0;
            act2       <= act1;
        end
    end

    generate
        if (MEM_LAT == 0) begin : g_no_lat
            assign pixel_valid = act2;
        end else begin : g_lat
            logic [MEM_LAT-1:0] vpipe;
            always_ff @(posedge clk) begin
                if (!rst) begin
                    vpipe <= '0;
                end else begin
                    vpipe[0] <= act2;
                    for (int i = 1; i < MEM_LAT; i++) vpipe[i] <= vpipe[i-1];
                end
            end
            assign pixel_valid = vpipe[MEM_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_bg_scroll_addr_gen.sv
// Directed bench for bg_scroll_addr_gen with default geometry and MEM_LAT=1.
module tb_bg_scroll_addr_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  h_cnt, v_cnt;
    logic [1:0]  scroll_mode;
    logic        step_tick;
    logic [3:0]  step;
    logic        step_neg;
    logic [16:0] pixel_addr;
    logic        pixel_valid;
    logic [8:0]  x_off;
    logic [7:0]  y_off;

    int total = 0;
    int bad   = 0;

    bg_scroll_addr_gen dut (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt),
        .scroll_mode(scroll_mode), .step_tick(step_tick), .step(step),
        .step_neg(step_neg), .pixel_addr(pixel_addr), .pixel_valid(pixel_valid),
        .x_off(x_off), .y_off(y_off)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic present(input int h, input int v);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        present(700, 500);
        cyc(2);
        rst = 1'b1;
        cyc(1);
    endtask

    task automatic do_tick(input int s, input logic neg);
        step      = 4'(s);
        step_neg  = neg;
        step_tick = 1'b1;
        cyc(1);
        step_tick = 1'b0;
    endtask

    task automatic frame();
        present(0, 480);
        cyc(1);
        present(700, 500);
    endtask

    initial begin
        rst = 1'b0; scroll_mode = 2'b00; step_tick = 1'b0; step = 4'd0; step_neg = 1'b0;
        present(700, 500);
        cyc(2);
        check("rst_addr",  32'(pixel_addr), 0);
        check("rst_valid", 32'(pixel_valid), 0);
        check("rst_xoff",  32'(x_off), 0);
        check("rst_yoff",  32'(y_off), 0);
        rst = 1'b1;
        cyc(1);

        // static mode, latency 2 for address, 3 for valid
        present(2, 2);      cyc(1);
        present(639, 479);  cyc(1);
        check("static_addr_2_2", 32'(pixel_addr), 321);
        check("static_valid_lat", 32'(pixel_valid), 0);
        present(0, 0);      cyc(1);
        check("static_addr_corner", 32'(pixel_addr), 76799);
        check("static_valid_on", 32'(pixel_valid), 1);
        present(700, 500);  cyc(1);
        check("static_addr_0_0", 32'(pixel_addr), 0);
        check("static_valid_corner", 32'(pixel_valid), 1);
        cyc(2);
        check("blank_valid", 32'(pixel_valid), 0);

        // horizontal scroll +10, pending not visible until frame start
        scroll_mode = 2'b01;
        do_tick(10, 1'b0);
        check("h_pending_hidden", 32'(x_off), 0);
        frame();
        check("h_xoff", 32'(x_off), 10);
        check("h_yoff", 32'(y_off), 0);
        present(620, 2);    cyc(1);
        present(0, 0);      cyc(1);
        check("h_wrap_addr", 32'(pixel_addr), 320);
        present(700, 500);  cyc(1);
        check("h_off_addr", 32'(pixel_addr), 10);

        // negative: 10-10=0, then 0-3 wraps to 317
        do_tick(10, 1'b1);
        do_tick(3, 1'b1);
        frame();
        check("hneg_xoff", 32'(x_off), 317);
        present(0, 2);      cyc(1);
        present(700, 500);  cyc(1);
        check("hneg_addr", 32'(pixel_addr), 637);

        // vertical, five unit steps, y wraps at SRC_H
        do_reset();
        scroll_mode = 2'b10;
        for (int i = 0; i < 5; i++) do_tick(1, 1'b0);
        frame();
        check("v_yoff", 32'(y_off), 5);
        check("v_xoff", 32'(x_off), 0);
        present(0, 478);    cyc(1);
        present(700, 500);  cyc(1);
        check("v_wrap_addr", 32'(pixel_addr), 1280);

        // static mode tick ignored
        scroll_mode = 2'b00;
        do_tick(7, 1'b0);
        frame();
        check("static_tick_x", 32'(x_off), 0);
        check("static_tick_y", 32'(y_off), 5);

        // vertical negative wrap: 5-7 -> 238
        scroll_mode = 2'b10;
        do_tick(7, 1'b1);
        frame();
        check("vneg_yoff", 32'(y_off), 238);

        // tick coincident with frame start
        do_reset();
        scroll_mode = 2'b11;
        step = 4'd4; step_neg = 1'b0;
        present(0, 480);
        step_tick = 1'b1;
        cyc(1);
        step_tick = 1'b0;
        present(700, 500);
        check("coinc_x_old", 32'(x_off), 0);
        check("coinc_y_old", 32'(y_off), 0);
        frame();
        check("coinc_x_new", 32'(x_off), 4);
        check("coinc_y_new", 32'(y_off), 4);
        present(0, 0);      cyc(1);
        present(700, 500);  cyc(1);
        check("diag_addr", 32'(pixel_addr), 1284);

        // mid-frame reset
        do_reset();
        scroll_mode = 2'b01;
        do_tick(10, 1'b0);
        frame();
        check("mid_xoff_pre", 32'(x_off), 10);
        present(100, 100);  cyc(3);
        check("mid_addr_pre", 32'(pixel_addr), 16060);
        check("mid_valid_pre", 32'(pixel_valid), 1);
        rst = 1'b0;
        cyc(1);
        check("mid_rst_addr", 32'(pixel_addr), 0);
        check("mid_rst_valid", 32'(pixel_valid), 0);
        check("mid_rst_xoff", 32'(x_off), 0);
        present(640, 0);
        rst = 1'b1;
        cyc(3);
        check("hblank_valid", 32'(pixel_valid), 0);
        check("hblank_addr", 32'(pixel_addr), 0);
        present(10, 480);   cyc(3);
        check("vblank_valid", 32'(pixel_valid), 0);
        check("vblank_addr", 32'(pixel_addr), 0);
        check("vblank_xoff", 32'(x_off), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bg_scroll_addr_gen.md
Name: bg_scroll_addr_gen

Overview:
Parametrised background address generator: maps VGA h_cnt/v_cnt to a scaled source-image ROM address, with wrap-around horizontal/vertical scrolling. Sits between the VGA controller and the background block ROM and replaces the fixed 2x downscale mapping. Offsets change only at frame boundaries (tear-free), and address and valid are pipelined so that pixel_valid lines up with ROM douta.

Parameters:
SRC_W, 320, source image width in pixels
SRC_H, 240, source image height in pixels
SCALE_SHIFT, 1, log2 of the upscale factor (screen px = src px << SCALE_SHIFT)
H_ACTIVE, 640, visible horizontal pixels
V_ACTIVE, 480, visible lines
ADDR_W, 17, ROM address width (must cover SRC_W*SRC_H-1)
MEM_LAT, 1, ROM read latency in cycles

Ports:
clk  in  1  system clock (single clock domain)
rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge)
h_cnt  in  10  VGA horizontal counter
v_cnt  in  10  VGA vertical counter
scroll_mode  in  2  00 static, 01 horizontal, 10 vertical, 11 diagonal
step_tick  in  1  one-cycle pulse that advances the pending offset
step  in  4  scroll step in source pixels, 0..15
step_neg  in  1  1 = scroll in the negative direction (subtract step)
pixel_addr  out  ADDR_W  ROM address, registered
pixel_valid  out  1  high when ROM douta holds a visible pixel
x_off  out  9  active horizontal offset, 0..SRC_W-1
y_off  out  8  active vertical offset, 0..SRC_H-1

Behaviour:
- Reset (rst==0 at a clk edge): pending and active offsets = 0, all pipeline stages cleared, pixel_addr = 0, pixel_valid = 0. A reset mid-frame takes effect on that edge. The first frame after reset uses offset 0.
- Pending offsets px/py update on step_tick only:
  - px moves only when scroll_mode[0]=1; py moves only when scroll_mode[1]=1.
  - Positive direction: px = px+step, minus SRC_W if the sum >= SRC_W.
  - Negative direction: px = px-step, plus SRC_W if the result < 0.
  - py uses the same rules with SRC_H.
  - A single correction is enough because step <= 15 < SRC_H.
- frame_start = (v_cnt==V_ACTIVE && h_cnt==0). On frame_start, active x_off/y_off <= px/py.
- step_tick and frame_start in the same cycle: the active offsets take the OLD pending value; the new pending value applies at the next frame_start.
- step_tick with scroll_mode=00: ignored, pending unchanged.
- Stage 1, registered:
  - sx = (h_cnt>>SCALE_SHIFT)+x_off, minus SRC_W if >= SRC_W.
  - sy = (v_cnt>>SCALE_SHIFT)+y_off, minus SRC_H if >= SRC_H.
  - act1 = (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE).
- Stage 2, registered: pixel_addr = act1 ? sy*SRC_W+sx : 0, with the product truncated to ADDR_W. act2 = act1.
- Latency:
  - pixel_addr is valid 2 cycles after h_cnt/v_cnt are presented.
  - pixel_valid = act2 delayed by MEM_LAT cycles, i.e. 2+MEM_LAT cycles after input, aligned to ROM douta.
- Outside the active region pixel_addr = 0 and the valid pipeline carries 0.
- Multiplication by SRC_W is a constant multiply; the tool infers a shift-add.

Decomposition:
- Shared package bg_pkg holds:
  - scroll_mode encodings: MODE_STATIC, MODE_H, MODE_V, MODE_DIAG;
  - default SRC_W/SRC_H/H_ACTIVE/V_ACTIVE constants.
- One natural sub-module, bg_offset_wrap: a modular add/subtract of step against a limit. It is instantiated twice, once for x with SRC_W and once for y with SRC_H.
- Pipeline and valid delay line stay in the top module.

Test Plan:
- Reset, static mode; h=0,v=0 -> pixel_addr=0 after 2 cycles; h=639,v=479 -> pixel_addr=76799; pixel_valid goes high 3 cycles after input (MEM_LAT=1).
- Mode 01, one step_tick with step=10, then frame_start -> x_off=10; h=620,v=0 -> sx wraps 320->0 -> pixel_addr=0.
- Mode 01, step_neg=1, step=3, from x_off=0 -> after frame_start x_off=317; h=0,v=2 -> pixel_addr=1*320+317=637.
- Mode 10, five ticks with step=1 -> y_off=5; h=0,v=478 -> sy=244-240=4 -> pixel_addr=1280; x_off remains 0.
- step_tick coincident with frame_start (pending 0, step 4, mode 11) -> x_off/y_off stay 0 this frame and become 4/4 at the next frame_start.
- rst=0 asserted mid-frame with x_off=10 -> next edge: pixel_addr=0, pixel_valid=0, x_off=0; h=640 or v=480 in blanking -> pixel_valid=0, pixel_addr=0.
